// File: rtl/enigma_pkg.sv
// Shared Enigma datapath types and ASCII-to-letter conversion.
// ASCII_LOWERCASE_FOLD_EN: when defined, lower-case ASCII is folded to upper case.
package enigma_pkg;

    typedef enum logic [4:0] {
        LET_A, LET_B, LET_C, LET_D, LET_E, LET_F, LET_G, LET_H, LET_I,
        LET_J, LET_K, LET_L, LET_M, LET_N, LET_O, LET_P, LET_Q, LET_R,
        LET_S, LET_T, LET_U, LET_V, LET_W, LET_X, LET_Y, LET_Z
    } letter_t;

    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;

    typedef struct packed {
        logic    valid;
        letter_t letter;
    } ascii_class_t;

    function automatic ascii_class_t ascii_to_letter(input logic [7:0] b);
        ascii_class_t r;
        r.valid  = 1'b0;
        r.letter = LET_A;
        if (b >= ASCII_UPPER_A && b <= ASCII_UPPER_Z) begin
            r.valid  = 1'b1;
            r.letter = letter_t'(5'(b - ASCII_UPPER_A));
        end
`ifdef ASCII_LOWERCASE_FOLD_EN
        else if (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z) begin
            r.valid  = 1'b1;
            r.letter = letter_t'(5'(b - ASCII_LOWER_A));
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/letter_fifo.sv
// Circular-buffer letter FIFO with first-word fall-through head and a separate
// occupancy register; flush empties the buffer and overrides push/pop.
module letter_fifo
    import enigma_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  letter_t                  push_letter_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output letter_t                  head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;

    letter_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          do_push, do_pop;

    assign full_o      = (occ_q == OW'(DEPTH));
    assign empty_o     = (occ_q == '0);
    assign occupancy_o = occ_q;
    assign head_o      = empty_o ? LET_A : mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   occ_d = occ_q + OW'(1);
                2'b01:   occ_d = occ_q - OW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_letter_i;
    end

endmodule

// File: rtl/ascii_letter_feeder.sv
// ASCII byte stream to letter_t feeder: classifies, buffers and counts.
// ASCII_LOWERCASE_FOLD_EN (see enigma_pkg) selects lower-case folding.
module ascii_letter_feeder
    import enigma_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output letter_t                out_letter,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CW-1:0]          letter_count,
    output logic [CW-1:0]          dropped_count
);

    ascii_class_t  cls;
    logic          full, empty;
    logic          accept, push, drop, pop;
    logic [CW-1:0] letter_count_q, letter_count_d;
    logic [CW-1:0] dropped_count_q, dropped_count_d;

    assign cls = ascii_to_letter(in_byte);

    // Readiness ignores out_ready so a same-cycle pop never opens a full FIFO.
    assign in_ready  = !full && !flush;
    assign out_valid = !empty;

    assign accept = in_valid && in_ready;
    assign push   = accept && cls.valid;
    assign drop   = accept && !cls.valid;
    assign pop    = out_valid && out_ready;

    letter_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .push_i        (push),
        .push_letter_i (cls.letter),
        .pop_i         (pop),
        .full_o        (full),
        .empty_o       (empty),
        .occupancy_o   (occupancy),
        .head_o        (out_letter)
    );

    always_comb begin
        letter_count_d  = letter_count_q;
        dropped_count_d = dropped_count_q;
        if (pop && letter_count_q != '1)  letter_count_d  = letter_count_q + CW'(1);
        if (drop && dropped_count_q != '1) dropped_count_d = dropped_count_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            letter_count_q  <= '0;
            dropped_count_q <= '0;
        end else begin
            letter_count_q  <= letter_count_d;
            dropped_count_q <= dropped_count_d;
        end
    end

    assign letter_count  = letter_count_q;
    assign dropped_count = dropped_count_q;

endmodule

// File: tb/tb_ascii_letter_feeder.sv
// Directed bench for ascii_letter_feeder with a queue-based reference model.
module tb_ascii_letter_feeder;

    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0]             in_byte;
    logic                   in_valid;
    logic                   in_ready;
    logic                   flush;
    logic [4:0]             out_letter;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CW-1:0]          letter_count;
    logic [CW-1:0]          dropped_count;

    int checks = 0;
    int errors = 0;

    int mq[$];
    int m_lc = 0;
    int m_dc = 0;

`ifdef ASCII_LOWERCASE_FOLD_EN
    localparam int FOLD = 1;
`else
    localparam int FOLD = 0;
`endif

    always #5 clk = ~clk;

    ascii_letter_feeder #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_byte       (in_byte),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .out_letter    (out_letter),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .occupancy     (occupancy),
        .letter_count  (letter_count),
        .dropped_count (dropped_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Letter index 0..25, or -1 if the byte is not a letter in this build.
    function automatic int classify(input logic [7:0] b);
        if (b >= 8'h41 && b <= 8'h5A) return int'(b) - 65;
        if (FOLD != 0 && b >= 8'h61 && b <= 8'h7A) return int'(b) - 97;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_lc = 0;
            m_dc = 0;
        end else begin
            automatic bit rdy    = (mq.size() < DEPTH) && !flush;
            automatic bit popped = (mq.size() != 0) && out_ready;
            automatic int c      = classify(in_byte);
            if (popped) begin
                void'(mq.pop_front());
                if (m_lc < MAXC) m_lc++;
            end
            if (flush) mq.delete();
            else if (in_valid && rdy) begin
                if (c >= 0) mq.push_back(c);
                else if (m_dc < MAXC) m_dc++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, (mq.size() < DEPTH) && !flush);
            chk("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) chk("out_letter", out_letter, mq[0]);
            chk("occupancy", occupancy, mq.size());
            chk("letter_count", letter_count, m_lc);
            chk("dropped_count", dropped_count, m_dc);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0h not accepted, expected acceptance within 50 cycles", b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc_base;
        int dc_base;
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; flush = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_letter", out_letter, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_letter_count", letter_count, 0);
        chk("rst_dropped_count", dropped_count, 0);

        send(8'h41);
        chk("ord_valid_latency", out_valid, 1);
        chk("ord_head_A", out_letter, 0);
        send(8'h42);
        chk("ord_occupancy", occupancy, 2);
        out_ready = 1'b1;
        step();
        chk("ord_head_B", out_letter, 1);
        step();
        out_ready = 1'b0;
        chk("ord_letter_count", letter_count, 2);
        chk("ord_empty", out_valid, 0);

        send(8'h20);
        send(8'h31);
        send(8'h5B);
        chk("drop_count", dropped_count, 3);
        chk("drop_no_output", out_valid, 0);
        chk("drop_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) send(8'h41 + 8'(i));
        chk("full_occupancy", occupancy, 8);
        chk("full_in_ready", in_ready, 0);
        in_byte = 8'h5A;
        in_valid = 1'b1;
        step();
        step();
        chk("full_hold_ready", in_ready, 0);
        chk("full_hold_occ", occupancy, 8);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("full_pop_occ", occupancy, 7);
        chk("full_ready_after_pop", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("full_refill_occ", occupancy, 8);
        out_ready = 1'b1;
        repeat (9) step();
        out_ready = 1'b0;
        chk("full_drained", out_valid, 0);
        chk("full_letter_count", letter_count, 11);

        send(8'h71);
        if (FOLD != 0) begin
            chk("fold_valid", out_valid, 1);
            chk("fold_letter_Q", out_letter, 16);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end else begin
            chk("nofold_dropped", dropped_count, 4);
            chk("nofold_no_output", out_valid, 0);
        end
        lc_base = 11 + FOLD;
        dc_base = 4 - FOLD;

        send(8'h41);
        send(8'h42);
        send(8'h43);
        chk("flush_pre_occ", occupancy, 3);
        in_byte = 8'h44;
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_occ", occupancy, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_lc", letter_count, lc_base);
        chk("flush_dc", dropped_count, dc_base);

        send(8'h41);
        send(8'h42);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("flush_pop_occ", occupancy, 0);
        chk("flush_pop_lc", letter_count, lc_base + 1);

        repeat (20) send(8'h2E);
        chk("sat_dropped", dropped_count, MAXC);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
        step();
        step();
        out_ready = 1'b0;
        chk("sat_letters", letter_count, MAXC);
        chk("sat_empty", out_valid, 0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
